alu_op_sequencer: RTL

- Multi-cycle initiator that drives the ALU operand, control and inc_pc inputs, then captures its 64-bit z_Output.
- Accepts one operation per start/done handshake, latches the result into ZLo/ZHi result registers, and performs the PC increment through the ALU.
- Sits between the instruction control unit and the ALU datapath.

---
 rtl/alu_op_sequencer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer
// Purpose  : Multi-cycle initiator for the ALU datapath. It accepts one
//            operation per start/done handshake, presents the operands and
//            the control code, and captures the 64-bit result into ZLo/ZHi.
//            It then runs the PC increment through the ALU and reports the
//            new PC.
// Options  : ALU_SEQ_DIVZERO_TRAP_EN - when defined, op 0 with a zero divisor
//            is trapped: illegal is set, EXEC is skipped and both result
//            words are forced to all ones.
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
  parameter int NUM_OPS      = 12,
  parameter int SHIFT_MASK_W = 5
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        start,
  input  logic [3:0]  op_code,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [31:0] pc_in,
  input  logic [63:0] z_Output,
  output logic [31:0] alu_reg1,
  output logic [31:0] alu_reg2,
  output logic [3:0]  alu_control,
  output logic        alu_inc_pc,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi,
  output logic [31:0] pc_out
);

  localparam logic [3:0]  c_ALU_NOP    = 4'hF;
  localparam logic [4:0]  c_NUM_OPS    = 5'(NUM_OPS);
  localparam logic [31:0] c_SHIFT_MASK = 32'((64'd1 << SHIFT_MASK_W) - 64'd1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_EXEC  = 3'd2,
    S_PCINC = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_op, w_op;
  logic [31:0] r_pc, w_pc;
  logic [31:0] r_alu_reg1, w_alu_reg1;
  logic [31:0] r_alu_reg2, w_alu_reg2;
  logic [3:0]  r_alu_control, w_alu_control;
  logic        r_alu_inc_pc, w_alu_inc_pc;
  logic        r_done, w_done;
  logic        r_illegal, w_illegal;
  logic [31:0] r_result_lo, w_result_lo;
  logic [31:0] r_result_hi, w_result_hi;
  logic [31:0] r_pc_out, w_pc_out;
  logic        w_shift_op;
  logic        w_illegal_op;
  logic        w_divzero;

  // Shift/rotate codes 4..7 share the 01xx pattern; the mask is applied at latch time.
  assign w_shift_op   = (op_code[3:2] == 2'b01);
  assign w_illegal_op = ({1'b0, r_op} >= c_NUM_OPS);

  // In SETUP alu_reg2 still holds the unmasked latched divisor for op 0.
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
  assign w_divzero = (r_op == 4'd0) && (r_alu_reg2 == 32'd0);
`else
  assign w_divzero = 1'b0;
`endif

  // Next-state and next-output computation; every ALU-facing output is registered.
  always_comb begin
    w_next        = r_state;
    w_op          = r_op;
    w_pc          = r_pc;
    w_alu_reg1    = r_alu_reg1;
    w_alu_reg2    = r_alu_reg2;
    w_alu_control = r_alu_control;
    w_alu_inc_pc  = r_alu_inc_pc;
    w_done        = 1'b0;
    w_illegal     = r_illegal;
    w_result_lo   = r_result_lo;
    w_result_hi   = r_result_hi;
    w_pc_out      = r_pc_out;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_op          = op_code;
          w_pc          = pc_in;
          w_alu_reg1    = operand_a;
          w_alu_reg2    = w_shift_op ? (operand_b & c_SHIFT_MASK) : operand_b;
          w_alu_control = c_ALU_NOP;
          w_alu_inc_pc  = 1'b0;
          w_illegal     = 1'b0;
          w_next        = S_SETUP;
        end
      end
      S_SETUP: begin
        if (w_illegal_op || w_divzero) begin
          w_illegal     = 1'b1;
          w_alu_reg2    = r_pc;
          w_alu_inc_pc  = 1'b1;
          w_alu_control = c_ALU_NOP;
          if (w_divzero) begin
            w_result_lo = 32'hFFFF_FFFF;
            w_result_hi = 32'hFFFF_FFFF;
          end
          w_next = S_PCINC;
        end else begin
          w_alu_control = r_op;
          w_next        = S_EXEC;
        end
      end
      S_EXEC: begin
        w_result_lo = z_Output[31:0];
        if (r_op == 4'd0 || r_op == 4'd1) begin
          w_result_hi = z_Output[63:32];
        end
        w_alu_reg2    = r_pc;
        w_alu_inc_pc  = 1'b1;
        w_alu_control = c_ALU_NOP;
        w_next        = S_PCINC;
      end
      S_PCINC: begin
        w_pc_out     = z_Output[31:0];
        w_alu_inc_pc = 1'b0;
        w_done       = 1'b1;
        w_next       = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous clear; control idles at the ALU no-op code.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state       <= S_IDLE;
      r_op          <= 4'd0;
      r_pc          <= 32'd0;
      r_alu_reg1    <= 32'd0;
      r_alu_reg2    <= 32'd0;
      r_alu_control <= c_ALU_NOP;
      r_alu_inc_pc  <= 1'b0;
      r_done        <= 1'b0;
      r_illegal     <= 1'b0;
      r_result_lo   <= 32'd0;
      r_result_hi   <= 32'd0;
      r_pc_out      <= 32'd0;
    end else begin
      r_state       <= w_next;
      r_op          <= w_op;
      r_pc          <= w_pc;
      r_alu_reg1    <= w_alu_reg1;
      r_alu_reg2    <= w_alu_reg2;
      r_alu_control <= w_alu_control;
      r_alu_inc_pc  <= w_alu_inc_pc;
      r_done        <= w_done;
      r_illegal     <= w_illegal;
      r_result_lo   <= w_result_lo;
      r_result_hi   <= w_result_hi;
      r_pc_out      <= w_pc_out;
    end
  end

  assign alu_reg1    = r_alu_reg1;
  assign alu_reg2    = r_alu_reg2;
  assign alu_control = r_alu_control;
  assign alu_inc_pc  = r_alu_inc_pc;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign illegal     = r_illegal;
  assign result_lo   = r_result_lo;
  assign result_hi   = r_result_hi;
  assign pc_out      = r_pc_out;

endmodule
`default_nettype wire
